// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, its two requesters and main memory.
// slave is the arbiter's view; master is the environment driving requests and memory.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_SIZE = 15,
    parameter int unsigned BUS_SIZE  = 16
);
    logic [1:0]           req0_cmd;
    logic [ADDR_SIZE-1:0] req0_addr;
    logic [BUS_SIZE-1:0]  req0_wdata;
    logic                 req0_wready;
    logic [BUS_SIZE-1:0]  req0_rdata;
    logic                 req0_rvalid;
    logic                 req0_done;
    logic                 req0_err;

    logic [1:0]           req1_cmd;
    logic [ADDR_SIZE-1:0] req1_addr;
    logic [BUS_SIZE-1:0]  req1_wdata;
    logic                 req1_wready;
    logic [BUS_SIZE-1:0]  req1_rdata;
    logic                 req1_rvalid;
    logic                 req1_done;
    logic                 req1_err;

    logic [1:0]           mem_command;
    logic [ADDR_SIZE-1:0] mem_address;
    logic [BUS_SIZE-1:0]  mem_wdata;
    logic [1:0]           mem_resp;
    logic [BUS_SIZE-1:0]  mem_rdata;

    modport slave (
        input  req0_cmd, req0_addr, req0_wdata, req1_cmd, req1_addr, req1_wdata,
               mem_resp, mem_rdata,
        output req0_wready, req0_rdata, req0_rvalid, req0_done, req0_err,
               req1_wready, req1_rdata, req1_rvalid, req1_done, req1_err,
               mem_command, mem_address, mem_wdata
    );

    modport master (
        output req0_cmd, req0_addr, req0_wdata, req1_cmd, req1_addr, req1_wdata,
               mem_resp, mem_rdata,
        input  req0_wready, req0_rdata, req0_rvalid, req0_done, req0_err,
               req1_wready, req1_rdata, req1_rvalid, req1_done, req1_err,
               mem_command, mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting one of two requesters a full-line burst to main memory,
// with write streaming, registered read beats and a response timeout.
module mem_arbiter #(
    parameter int unsigned ADDR_SIZE = 15,
    parameter int unsigned BUS_SIZE  = 16,
    parameter int unsigned BEATS     = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CntW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] CmdNop   = 2'd0;
    localparam logic [1:0] CmdResp  = 2'd1;
    localparam logic [1:0] CmdRead  = 2'd2;
    localparam logic [1:0] CmdWrite = 2'd3;

    localparam logic [BeatW-1:0] LastWBeat = BeatW'(BEATS - 1);
    localparam logic [BeatW-1:0] LastRBeat = BeatW'(BEATS - 2);
    localparam logic [CntW-1:0]  LastWait  = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StCmd, StWdata, StWaitResp, StRdata, StDone} state_e;

    state_e               state_q, state_d;
    logic                 gnt_q;
    logic                 last_grant_q;
    logic                 is_write_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [BeatW-1:0]     beat_q;
    logic [CntW-1:0]      cnt_q;
    logic                 err_q;
    logic                 rvalid_q;
    logic [BUS_SIZE-1:0]  rdata0_q, rdata1_q;

    logic [1:0]           req_vld;
    logic                 winner;
    logic                 resp_hit;
    logic                 capture;

    logic [1:0]           mem_cmd;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [BUS_SIZE-1:0]  mem_wd;
    logic [1:0]           wready, done, err;

    // READ and WRITE are the only encodings with bit 1 set
    assign req_vld  = {bus.req1_cmd[1], bus.req0_cmd[1]};
    assign winner   = (req_vld == 2'b11) ? ~last_grant_q : req_vld[1];
    assign resp_hit = (bus.mem_resp == CmdResp);
    assign capture  = ((state_q == StWaitResp) && resp_hit && !is_write_q) ||
                      (state_q == StRdata);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (|req_vld) state_d = StCmd;
            StCmd:      state_d = is_write_q ? StWdata : StWaitResp;
            StWdata:    if (beat_q == LastWBeat) state_d = StWaitResp;
            StWaitResp: begin
                if (resp_hit) begin
                    state_d = (is_write_q || BEATS < 2) ? StDone : StRdata;
                end else if (cnt_q == LastWait) begin
                    state_d = StDone;
                end
            end
            StRdata:    if (beat_q == LastRBeat) state_d = StDone;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_cmd  = CmdNop;
        mem_addr = '0;
        mem_wd   = '0;
        wready   = '0;
        done     = '0;
        err      = '0;
        case (state_q)
            StCmd: begin
                mem_cmd  = is_write_q ? CmdWrite : CmdRead;
                mem_addr = addr_q;
            end
            StWdata: begin
                mem_cmd        = CmdWrite;
                mem_addr       = addr_q;
                mem_wd         = gnt_q ? bus.req1_wdata : bus.req0_wdata;
                wready[gnt_q]  = 1'b1;
            end
            StDone: begin
                done[gnt_q] = 1'b1;
                err[gnt_q]  = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            is_write_q   <= 1'b0;
            addr_q       <= '0;
            beat_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            rvalid_q <= capture;
            if (capture) begin
                if (gnt_q) rdata1_q <= bus.mem_rdata;
                else       rdata0_q <= bus.mem_rdata;
            end
            case (state_q)
                StIdle: begin
                    if (|req_vld) begin
                        gnt_q        <= winner;
                        last_grant_q <= winner;
                        is_write_q   <= winner ? bus.req1_cmd[0] : bus.req0_cmd[0];
                        addr_q       <= winner ? bus.req1_addr : bus.req0_addr;
                        beat_q       <= '0;
                        cnt_q        <= '0;
                        err_q        <= 1'b0;
                    end
                end
                StWdata:    beat_q <= (beat_q == LastWBeat) ? '0 : beat_q + 1'b1;
                StWaitResp: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!resp_hit && cnt_q == LastWait) err_q <= 1'b1;
                end
                StRdata:    beat_q <= beat_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.mem_command = mem_cmd;
    assign bus.mem_address = mem_addr;
    assign bus.mem_wdata   = mem_wd;
    assign bus.req0_wready = wready[0];
    assign bus.req1_wready = wready[1];
    assign bus.req0_done   = done[0];
    assign bus.req1_done   = done[1];
    assign bus.req0_err    = err[0];
    assign bus.req1_err    = err[1];
    assign bus.req0_rvalid = rvalid_q & ~gnt_q;
    assign bus.req1_rvalid = rvalid_q & gnt_q;
    assign bus.req0_rdata  = rdata0_q;
    assign bus.req1_rdata  = rdata1_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model expands each request into the
// expected per-cycle bus timeline, and one compare process checks every cycle against it.
module tb_mem_arbiter;
    localparam int unsigned AW      = 15;
    localparam int unsigned DW      = 16;
    localparam int unsigned BEATS   = 8;
    localparam int unsigned TIMEOUT = 255;

    localparam logic [1:0] NOP  = 2'd0;
    localparam logic [1:0] RESP = 2'd1;
    localparam logic [1:0] RD   = 2'd2;
    localparam logic [1:0] WR   = 2'd3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_SIZE(AW), .BUS_SIZE(DW)) bus ();

    mem_arbiter #(
        .ADDR_SIZE(AW),
        .BUS_SIZE (DW),
        .BEATS    (BEATS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic          rst;
        logic [1:0]    cmd0, cmd1;
        logic [AW-1:0] addr0, addr1;
        logic [DW-1:0] wd0, wd1;
        logic [1:0]    resp;
        logic [DW-1:0] mrd;
        logic [1:0]    e_mcmd;
        logic [AW-1:0] e_maddr;
        logic [DW-1:0] e_mwd;
        logic [1:0]    e_wready, e_rvalid, e_done, e_err;
        logic [DW-1:0] e_rd0, e_rd1;
    } cyc_t;

    int    tests = 0;
    int    fails = 0;
    cyc_t  cur;
    bit    chk = 1'b0;
    string name = "reset";
    int    cyc = 0;

    // model state: round-robin pointer and last read beat per requester
    int            m_last = 1;
    logic [DW-1:0] m_rd [2] = '{16'h0, 16'h0};

    int rv_cnt [2] = '{0, 0};
    int wr_cnt [2] = '{0, 0};
    int rdcmd_cnt = 0;
    int cmd_cyc = 0;
    int done_cyc = 0;
    int done_order [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk) begin
            tests++;
            if (bus.mem_command !== cur.e_mcmd || bus.mem_address !== cur.e_maddr ||
                bus.mem_wdata !== cur.e_mwd ||
                {bus.req1_wready, bus.req0_wready} !== cur.e_wready ||
                {bus.req1_rvalid, bus.req0_rvalid} !== cur.e_rvalid ||
                {bus.req1_done, bus.req0_done} !== cur.e_done ||
                {bus.req1_err, bus.req0_err} !== cur.e_err ||
                bus.req0_rdata !== cur.e_rd0 || bus.req1_rdata !== cur.e_rd1) begin
                fails++;
                $display("FAIL %s cyc=%0d got cmd=%0d addr=%h wd=%h wr=%b rv=%b dn=%b er=%b rd0=%h rd1=%h | want cmd=%0d addr=%h wd=%h wr=%b rv=%b dn=%b er=%b rd0=%h rd1=%h",
                         name, cyc, bus.mem_command, bus.mem_address, bus.mem_wdata,
                         {bus.req1_wready, bus.req0_wready}, {bus.req1_rvalid, bus.req0_rvalid},
                         {bus.req1_done, bus.req0_done}, {bus.req1_err, bus.req0_err},
                         bus.req0_rdata, bus.req1_rdata, cur.e_mcmd, cur.e_maddr, cur.e_mwd,
                         cur.e_wready, cur.e_rvalid, cur.e_done, cur.e_err, cur.e_rd0, cur.e_rd1);
            end
        end
        if (bus.req0_rvalid === 1'b1) rv_cnt[0]++;
        if (bus.req1_rvalid === 1'b1) rv_cnt[1]++;
        if (bus.req0_wready === 1'b1) wr_cnt[0]++;
        if (bus.req1_wready === 1'b1) wr_cnt[1]++;
        if (bus.mem_command === RD) begin
            rdcmd_cnt++;
            cmd_cyc = cyc;
        end
        if (bus.req0_done === 1'b1) begin
            done_cyc = cyc;
            done_order.push_back(0);
        end
        if (bus.req1_done === 1'b1) begin
            done_cyc = cyc;
            done_order.push_back(1);
        end
    end

    task automatic apply(input cyc_t r);
        cur            = r;
        reset          = r.rst;
        bus.req0_cmd   = r.cmd0;
        bus.req0_addr  = r.addr0;
        bus.req0_wdata = r.wd0;
        bus.req1_cmd   = r.cmd1;
        bus.req1_addr  = r.addr1;
        bus.req1_wdata = r.wd1;
        bus.mem_resp   = r.resp;
        bus.mem_rdata  = r.mrd;
        chk            = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic cyc_t base_rec(input logic [1:0] c0, input logic [AW-1:0] a0,
                                      input logic [1:0] c1, input logic [AW-1:0] a1);
        cyc_t r;
        r.rst      = 1'b1;
        r.cmd0     = c0;
        r.addr0    = a0;
        r.cmd1     = c1;
        r.addr1    = a1;
        r.wd0      = 16'h5A5A;
        r.wd1      = 16'hA5A5;
        r.resp     = NOP;
        r.mrd      = 16'hBEEF;
        r.e_mcmd   = NOP;
        r.e_maddr  = '0;
        r.e_mwd    = '0;
        r.e_wready = '0;
        r.e_rvalid = '0;
        r.e_done   = '0;
        r.e_err    = '0;
        r.e_rd0    = m_rd[0];
        r.e_rd1    = m_rd[1];
        return r;
    endfunction

    task automatic idle(input int n, input logic rst, input logic [1:0] resp);
        cyc_t r;
        if (!rst) begin
            m_last  = 1;
            m_rd[0] = '0;
            m_rd[1] = '0;
        end
        for (int i = 0; i < n; i++) begin
            r      = base_rec(NOP, '0, NOP, '0);
            r.rst  = rst;
            r.resp = resp;
            r.mrd  = 16'h1111;
            apply(r);
        end
    endtask

    // Expand one granted transaction into its cycle timeline; rst_beat >= 0 pulls reset
    // during the cycle that would capture that read beat.
    task automatic run_txn(input string nm, input logic [1:0] c0, input logic [AW-1:0] a0,
                           input logic [1:0] c1, input logic [AW-1:0] a1, input int delay,
                           input bit never, input logic [DW-1:0] base, input int rst_beat,
                           input bit scramble);
        cyc_t          q [$];
        cyc_t          r;
        int            w, cap0, idx, n_wait;
        logic [1:0]    wc;
        logic [AW-1:0] wa;
        bit            wr;
        logic [DW-1:0] hold [2];
        name   = nm;
        w      = (c0[1] && c1[1]) ? 1 - m_last : (c1[1] ? 1 : 0);
        m_last = w;
        wc     = (w == 1) ? c1 : c0;
        wa     = (w == 1) ? a1 : a0;
        wr     = (wc == WR);
        q.push_back(base_rec(c0, a0, c1, a1));
        if (scramble) begin
            if (w == 0) begin
                c0 = c0 ^ 2'b01;
                a0 = ~a0;
            end else begin
                c1 = c1 ^ 2'b01;
                a1 = ~a1;
            end
        end
        r         = base_rec(c0, a0, c1, a1);
        r.e_mcmd  = wc;
        r.e_maddr = wa;
        q.push_back(r);
        if (wr) begin
            for (int k = 0; k < int'(BEATS); k++) begin
                r             = base_rec(c0, a0, c1, a1);
                r.wd0         = (w == 0) ? base + 16'(k) : 16'h5500 + 16'(k);
                r.wd1         = (w == 1) ? base + 16'(k) : 16'h6600 + 16'(k);
                if (k == 3) r.resp = RESP;
                r.e_mcmd      = WR;
                r.e_maddr     = wa;
                r.e_mwd       = base + 16'(k);
                r.e_wready[w] = 1'b1;
                q.push_back(r);
            end
        end
        cap0   = q.size() + delay;
        n_wait = never ? int'(TIMEOUT) : delay + 1;
        for (int k = 0; k < n_wait; k++) begin
            r = base_rec(c0, a0, c1, a1);
            if (!never && k == delay) begin
                r.resp = RESP;
                r.mrd  = base;
            end
            q.push_back(r);
        end
        if (!never && !wr) begin
            for (int k = 1; k < int'(BEATS); k++) begin
                r      = base_rec(c0, a0, c1, a1);
                r.mrd  = base + 16'(k);
                r.resp = 2'(k);
                q.push_back(r);
            end
        end
        r           = base_rec(c0, a0, c1, a1);
        r.e_done[w] = 1'b1;
        r.e_err[w]  = never;
        q.push_back(r);
        hold[0] = m_rd[0];
        hold[1] = m_rd[1];
        for (int j = 0; j < q.size(); j++) begin
            r = q[j];
            if (!never && !wr && j > cap0 && j <= cap0 + int'(BEATS)) begin
                hold[w]       = base + 16'(j - 1 - cap0);
                r.e_rvalid[w] = 1'b1;
            end
            r.e_rd0 = hold[0];
            r.e_rd1 = hold[1];
            q[j]    = r;
        end
        if (rst_beat < 0) begin
            foreach (q[j]) apply(q[j]);
            m_rd[w] = hold[w];
        end else begin
            idx = cap0 + rst_beat;
            for (int j = 0; j < idx; j++) apply(q[j]);
            m_last  = 1;
            m_rd[0] = '0;
            m_rd[1] = '0;
            r       = base_rec(q[idx].cmd0, q[idx].addr0, q[idx].cmd1, q[idx].addr1);
            r.rst   = 1'b0;
            r.resp  = q[idx].resp;
            r.mrd   = q[idx].mrd;
            apply(r);
            r.resp  = NOP;
            apply(r);
        end
    endtask

    task automatic pin(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    int rv0_b, rv1_b, wr1_b, rdc_b, dn_b;

    initial begin
        reset          = 1'b0;
        bus.req0_cmd   = NOP;
        bus.req0_addr  = '0;
        bus.req0_wdata = '0;
        bus.req1_cmd   = NOP;
        bus.req1_addr  = '0;
        bus.req1_wdata = '0;
        bus.mem_resp   = NOP;
        bus.mem_rdata  = '0;
        @(posedge clk);
        #1;
        idle(2, 1'b0, NOP);
        name = "spurious_idle";
        idle(3, 1'b1, RESP);

        rv0_b = rv_cnt[0];
        rdc_b = rdcmd_cnt;
        run_txn("single_read", RD, 15'h1234, RESP, 15'h0999, 2, 1'b0, 16'h0001, -1, 1'b0);
        pin("read_beats", rv_cnt[0] - rv0_b, 8);
        pin("read_cmd_cycles", rdcmd_cnt - rdc_b, 1);
        pin("read_last_beat", int'(bus.req0_rdata), 16'h0008);

        wr1_b = wr_cnt[1];
        run_txn("single_write", NOP, 15'h0000, WR, 15'h0042, 1, 1'b0, 16'hA000, -1, 1'b0);
        pin("write_beats", wr_cnt[1] - wr1_b, 8);

        dn_b = done_order.size();
        run_txn("contend_a", RD, 15'h0100, RD, 15'h0200, 1, 1'b0, 16'h1000, -1, 1'b0);
        run_txn("contend_b", RD, 15'h0100, RD, 15'h0200, 0, 1'b0, 16'h2000, -1, 1'b0);
        run_txn("contend_c", RD, 15'h0100, RD, 15'h0200, 3, 1'b0, 16'h3000, -1, 1'b1);
        run_txn("contend_d", RD, 15'h0100, RD, 15'h0200, 1, 1'b0, 16'h4000, -1, 1'b0);
        pin("contend_count", done_order.size() - dn_b, 4);
        pin("contend_g0", done_order[dn_b], 0);
        pin("contend_g1", done_order[dn_b + 1], 1);
        pin("contend_g2", done_order[dn_b + 2], 0);
        pin("contend_g3", done_order[dn_b + 3], 1);

        run_txn("write_scramble", WR, 15'h0777, NOP, 15'h0000, 0, 1'b0, 16'hC000, -1, 1'b1);

        rv0_b = rv_cnt[0];
        rv1_b = rv_cnt[1];
        run_txn("timeout", NOP, 15'h0000, RD, 15'h7FFF, 0, 1'b1, 16'h0000, -1, 1'b0);
        pin("timeout_latency", done_cyc - cmd_cyc, 256);
        pin("timeout_no_rvalid", (rv_cnt[0] - rv0_b) + (rv_cnt[1] - rv1_b), 0);

        dn_b = done_order.size();
        run_txn("reset_mid", RD, 15'h0ABC, NOP, 15'h0000, 2, 1'b0, 16'h5000, 4, 1'b0);
        pin("reset_no_done", done_order.size() - dn_b, 0);
        run_txn("post_rst_both", RD, 15'h0011, RD, 15'h0022, 0, 1'b0, 16'h6000, -1, 1'b0);
        pin("post_rst_first", done_order[done_order.size() - 1], 0);
        run_txn("post_rst_req1", NOP, 15'h0000, RD, 15'h0033, 1, 1'b0, 16'h7000, -1, 1'b0);
        pin("post_rst_req1_grant", done_order[done_order.size() - 1], 1);

        name = "tail_idle";
        idle(3, 1'b1, RESP);
        chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
